// File: rtl/fpu_mul_scheduler_pkg.sv
// Shared constants, scheduler state type and operand classification for the
// single-precision multiplier scheduler.
package fpu_pkg;

  localparam logic [31:0] QNAN    = 32'h7FFF_FFFF;
  localparam logic [6:0]  RM_RNE  = 7'h01;
  localparam logic [7:0]  EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} sched_state_e;

  typedef struct packed {
    logic inf;
    logic nan;
  } fp_class_t;

  function automatic fp_class_t classify(input logic [7:0] exp_i, input logic [22:0] frac_i);
    fp_class_t c;
    c.inf = (exp_i == EXP_MAX) && (frac_i == '0);
    c.nan = (exp_i == EXP_MAX) && (frac_i != '0);
    return c;
  endfunction

endpackage

// File: rtl/fpu_mul_scheduler_if.sv
// Scheduler <-> multiplier bus: start pulse with decomposed operands out,
// completion pulse with result and exception flags back.
interface fpu_mul_scheduler_if;

  logic        mul_data_ready_o;
  logic [6:0]  mul_rounding_mode_o;
  logic        mul_x_sign_o;
  logic        mul_y_sign_o;
  logic [7:0]  mul_x_exp_o;
  logic [7:0]  mul_y_exp_o;
  logic [22:0] mul_x_frac_o;
  logic [22:0] mul_y_frac_o;
  logic        mul_x_infinity_o;
  logic        mul_y_infinity_o;
  logic        mul_x_nan_o;
  logic        mul_y_nan_o;
  logic        mul_data_valid_i;
  logic [31:0] mul_z_i;
  logic        mul_invalid_i;
  logic        mul_overflow_i;

  modport master (
    output mul_data_ready_o, mul_rounding_mode_o,
    output mul_x_sign_o, mul_y_sign_o, mul_x_exp_o, mul_y_exp_o,
    output mul_x_frac_o, mul_y_frac_o,
    output mul_x_infinity_o, mul_y_infinity_o, mul_x_nan_o, mul_y_nan_o,
    input  mul_data_valid_i, mul_z_i, mul_invalid_i, mul_overflow_i
  );

  modport slave (
    input  mul_data_ready_o, mul_rounding_mode_o,
    input  mul_x_sign_o, mul_y_sign_o, mul_x_exp_o, mul_y_exp_o,
    input  mul_x_frac_o, mul_y_frac_o,
    input  mul_x_infinity_o, mul_y_infinity_o, mul_x_nan_o, mul_y_nan_o,
    output mul_data_valid_i, mul_z_i, mul_invalid_i, mul_overflow_i
  );

endinterface

// File: rtl/fpu_mul_scheduler_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found when
// searching upward from last+1, wrapping modulo N_REQ.
module fpu_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic [N_REQ-1:0] o_grant,
  output logic [IW-1:0]    o_idx
);

  logic [IW-1:0] w_cand;
  logic          w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_cand = IW'((32'(i_last) + k) % N_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_mul_scheduler.sv
// Round-robin scheduler sharing one single-precision multiplier among N_REQ
// requesters, with a watchdog that substitutes a quiet-NaN timeout response.
module fpu_mul_scheduler
  import fpu_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  output logic [N_REQ-1:0]     req_ready_o,
  input  logic [32*N_REQ-1:0]  req_x_i,
  input  logic [32*N_REQ-1:0]  req_y_i,
  input  logic [7*N_REQ-1:0]   req_rounding_mode_i,
  output logic [N_REQ-1:0]     rsp_valid_o,
  output logic [31:0]          rsp_z_o,
  output logic                 rsp_invalid_o,
  output logic                 rsp_overflow_o,
  output logic                 rsp_timeout_o,
  output logic                 busy_o,
  fpu_mul_scheduler_if.master  mul_if
);

  localparam int unsigned IW  = $clog2(N_REQ);
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_e     r_state, w_next;
  logic [IW-1:0]    r_last, w_arb_idx;
  logic [N_REQ-1:0] w_arb_grant;
  logic [31:0]      r_x, r_y, r_z;
  logic [6:0]       r_rm;
  logic             r_inv, r_ovf, r_to;
  logic [WDW-1:0]   r_wd;
  logic             w_expire;
  logic [31:0]      w_x [N_REQ];
  logic [31:0]      w_y [N_REQ];
  logic [6:0]       w_rm [N_REQ];
  fp_class_t        w_x_cls, w_y_cls;

  fpu_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req   (req_valid_i),
    .i_last  (r_last),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx)
  );

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_x[i]  = req_x_i[32*i +: 32];
      w_y[i]  = req_y_i[32*i +: 32];
      w_rm[i] = req_rounding_mode_i[7*i +: 7];
    end
  end

  assign w_expire = !mul_if.mul_data_valid_i && (r_wd == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid_i != '0) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (mul_if.mul_data_valid_i || w_expire) w_next = RESPOND;
      RESPOND: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Pulses are suppressed while reset is asserted so a dropped request is never consumed.
  always_comb begin
    req_ready_o             = '0;
    rsp_valid_o             = '0;
    mul_if.mul_data_ready_o = 1'b0;
    busy_o                  = (r_state != IDLE);
    if (!rst_i) begin
      case (r_state)
        IDLE:    req_ready_o = w_arb_grant;
        ISSUE:   mul_if.mul_data_ready_o = 1'b1;
        RESPOND: rsp_valid_o[r_last] = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last <= IW'(N_REQ - 1);
      r_x    <= '0;
      r_y    <= '0;
      r_rm   <= '0;
      r_z    <= '0;
      r_inv  <= 1'b0;
      r_ovf  <= 1'b0;
      r_to   <= 1'b0;
      r_wd   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid_i != '0) begin
            r_x    <= w_x[w_arb_idx];
            r_y    <= w_y[w_arb_idx];
            r_rm   <= w_rm[w_arb_idx];
            r_last <= w_arb_idx;
          end
        end
        ISSUE: r_wd <= '0;
        WAIT: begin
          if (mul_if.mul_data_valid_i) begin
            r_z   <= mul_if.mul_z_i;
            r_inv <= mul_if.mul_invalid_i;
            r_ovf <= mul_if.mul_overflow_i;
            r_to  <= 1'b0;
          end else if (w_expire) begin
            r_z   <= QNAN;
            r_inv <= 1'b0;
            r_ovf <= 1'b0;
            r_to  <= 1'b1;
          end else if (r_wd != '1) begin
            r_wd <= r_wd + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_x_cls = classify(r_x[30:23], r_x[22:0]);
  assign w_y_cls = classify(r_y[30:23], r_y[22:0]);

  assign mul_if.mul_rounding_mode_o = r_rm;
  assign mul_if.mul_x_sign_o        = r_x[31];
  assign mul_if.mul_y_sign_o        = r_y[31];
  assign mul_if.mul_x_exp_o         = r_x[30:23];
  assign mul_if.mul_y_exp_o         = r_y[30:23];
  assign mul_if.mul_x_frac_o        = r_x[22:0];
  assign mul_if.mul_y_frac_o        = r_y[22:0];
  assign mul_if.mul_x_infinity_o    = w_x_cls.inf;
  assign mul_if.mul_y_infinity_o    = w_y_cls.inf;
  assign mul_if.mul_x_nan_o         = w_x_cls.nan;
  assign mul_if.mul_y_nan_o         = w_y_cls.nan;

  assign rsp_z_o        = r_z;
  assign rsp_invalid_o  = r_inv;
  assign rsp_overflow_o = r_ovf;
  assign rsp_timeout_o  = r_to;

endmodule

// File: tb/tb_fpu_mul_scheduler.sv
// Bench for fpu_mul_scheduler: behavioural multiplier stub, directed vector
// table, hand-written corner sequences and randomized round-robin traffic.
module tb_fpu_mul_scheduler;
  import fpu_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [32*N-1:0]  req_x = '0;
  logic [32*N-1:0]  req_y = '0;
  logic [7*N-1:0]   req_rm = '0;
  logic [N-1:0]     rsp_valid;
  logic [31:0]      rsp_z;
  logic             rsp_inv, rsp_ovf, rsp_to, busy;

  fpu_mul_scheduler_if mif();

  fpu_mul_scheduler #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .req_valid_i         (req_valid),
    .req_ready_o         (req_ready),
    .req_x_i             (req_x),
    .req_y_i             (req_y),
    .req_rounding_mode_i (req_rm),
    .rsp_valid_o         (rsp_valid),
    .rsp_z_o             (rsp_z),
    .rsp_invalid_o       (rsp_inv),
    .rsp_overflow_o      (rsp_ovf),
    .rsp_timeout_o       (rsp_to),
    .busy_o              (busy),
    .mul_if              (mif.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int unsigned m_last = N - 1;

  // Stand-in multiplier: NaN in -> quiet NaN + invalid, a few exact products, otherwise a scramble.
  function automatic logic [33:0] stub_mul(input logic [31:0] x, input logic [31:0] y);
    bit xn, yn;
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    if (xn || yn) return {32'h7FFF_FFFF, 1'b1, 1'b0};
    if (x == 32'h7F00_0000 && y == 32'h7F00_0000) return {32'h7F80_0000, 1'b0, 1'b1};
    if (x == 32'h4000_0000 && y == 32'h4040_0000) return {32'h40C0_0000, 1'b0, 1'b0};
    return {x ^ {y[15:0], y[31:16]}, 1'b0, 1'b0};
  endfunction

  logic        stub_hang = 1'b0;
  logic        inj_valid = 1'b0;
  int          stub_cnt  = 0;
  logic [31:0] stub_x, stub_y;

  always @(negedge clk) begin
    mif.mul_data_valid_i = 1'b0;
    if (rst) begin
      stub_cnt          = 0;
      mif.mul_z_i       = '0;
      mif.mul_invalid_i = 1'b0;
      mif.mul_overflow_i = 1'b0;
    end else begin
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          {mif.mul_z_i, mif.mul_invalid_i, mif.mul_overflow_i} = stub_mul(stub_x, stub_y);
          mif.mul_data_valid_i = 1'b1;
        end
      end
      if (mif.mul_data_ready_o) begin
        stub_x   = {mif.mul_x_sign_o, mif.mul_x_exp_o, mif.mul_x_frac_o};
        stub_y   = {mif.mul_y_sign_o, mif.mul_y_exp_o, mif.mul_y_frac_o};
        stub_cnt = stub_hang ? 0 : ((mif.mul_rounding_mode_o == RM_RNE) ? 4 : 3);
      end
    end
    if (inj_valid) mif.mul_data_valid_i = 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int unsigned model_pick(input logic [N-1:0] mask, input int unsigned last);
    for (int unsigned i = last + 1; i < N; i++) if (mask[i]) return i;
    for (int unsigned i = 0; i < N; i++) if (mask[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom % 8)
      0: return 32'h7FC0_0000 | ($urandom & 32'h003F_FFFF) | ({31'd0, 1'($urandom)} << 31);
      1: return {1'($urandom), 31'h7F80_0000};
      2: return {1'b0, 8'hFF, 23'h1};
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_grant(output bit ok);
    int c;
    c = 0;
    #1;
    while (req_ready == '0 && c < 60) begin
      tick();
      c++;
    end
    ok = (req_ready != '0);
  endtask

  // One transaction for requester g; operands/valids already set by the caller.
  task automatic serve(input string tag, input int unsigned g, input logic [31:0] ez,
                       input logic einv, input logic eovf, input logic eto,
                       input int unsigned elat, input bit hold);
    bit ok;
    int unsigned cyc;
    logic [31:0] xs, ys;
    logic [N-1:0] oh;
    xs = req_x[32*g +: 32];
    ys = req_y[32*g +: 32];
    oh = N'(1) << g;
    wait_grant(ok);
    if (!ok) begin
      chk({tag, "_grant_wait"}, 0, 1);
      req_valid = '0;
      return;
    end
    chk({tag, "_grant"}, req_ready, oh);
    m_last = g;
    tick();
    if (!hold) req_valid = '0;
    chk({tag, "_start"}, {mif.mul_data_ready_o, busy}, 2'b11);
    chk({tag, "_xfields"}, {mif.mul_x_sign_o, mif.mul_x_exp_o, mif.mul_x_frac_o}, xs);
    chk({tag, "_yfields"}, {mif.mul_y_sign_o, mif.mul_y_exp_o, mif.mul_y_frac_o}, ys);
    chk({tag, "_class"},
        {mif.mul_x_infinity_o, mif.mul_x_nan_o, mif.mul_y_infinity_o, mif.mul_y_nan_o},
        {xs[30:23] == 8'hFF && xs[22:0] == 0, xs[30:23] == 8'hFF && xs[22:0] != 0,
         ys[30:23] == 8'hFF && ys[22:0] == 0, ys[30:23] == 8'hFF && ys[22:0] != 0});
    chk({tag, "_rm"}, mif.mul_rounding_mode_o, req_rm[7*g +: 7]);
    tick();
    chk({tag, "_start_once"}, {mif.mul_data_ready_o, mif.mul_x_exp_o, mif.mul_y_frac_o},
        {1'b0, xs[30:23], ys[22:0]});
    cyc = 2;
    while (rsp_valid == '0 && cyc < 60) begin
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, cyc, elat);
    chk({tag, "_rsp_valid"}, rsp_valid, oh);
    chk({tag, "_rsp"}, {rsp_z, rsp_inv, rsp_ovf, rsp_to}, {ez, einv, eovf, eto});
    if (!hold) begin
      tick();
      chk({tag, "_idle_after"}, {busy, rsp_valid}, '0);
    end
  endtask

  typedef struct {
    int unsigned idx;
    logic [31:0] x, y;
    logic [6:0]  rm;
    bit          hang;
    logic [31:0] z;
    logic        inv, ovf, to;
    int unsigned lat;
  } vec_t;

  vec_t        vt [7];
  logic [33:0] exp_r;
  logic [N-1:0] mask;
  int unsigned g;
  bit          seen, ok;

  initial begin
    vt[0] = '{0, 32'h4000_0000, 32'h4040_0000, 7'h00, 0, 32'h40C0_0000, 0, 0, 0, 5};
    vt[1] = '{1, 32'h7FC0_0000, 32'h3F80_0000, 7'h00, 0, 32'h7FFF_FFFF, 1, 0, 0, 5};
    vt[2] = '{3, 32'h7F00_0000, 32'h7F00_0000, 7'h00, 0, 32'h7F80_0000, 0, 1, 0, 5};
    vt[3] = '{3, 32'h7F00_0000, 32'h7F00_0000, 7'h01, 0, 32'h7F80_0000, 0, 1, 0, 6};
    vt[4] = '{0, 32'h7F80_0000, 32'h4000_0000, 7'h15, 0, 32'h7F80_4000, 0, 0, 0, 5};
    vt[5] = '{2, 32'h3F80_0000, 32'hC000_0000, 7'h01, 0, 32'h3F80_C000, 0, 0, 0, 6};
    vt[6] = '{2, 32'h4000_0000, 32'h4040_0000, 7'h00, 1, 32'h7FFF_FFFF, 0, 0, 1, 2 + TO};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_ctl", {busy, req_ready, rsp_valid, mif.mul_data_ready_o, rsp_inv, rsp_ovf, rsp_to}, '0);
    chk("reset_z", rsp_z, 0);
    chk("reset_operands", {mif.mul_x_exp_o, mif.mul_x_frac_o, mif.mul_rounding_mode_o}, '0);

    // Requesters 0 and 2 held valid: pointer alternates between them.
    req_x[31:0]  = 32'h4000_0000;  req_y[31:0]  = 32'h4040_0000;
    req_x[95:64] = 32'h3F80_0000;  req_y[95:64] = 32'hC000_0000;
    req_rm       = '0;
    req_valid    = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 0) ? 0 : 2;
      exp_r = stub_mul(req_x[32*g +: 32], req_y[32*g +: 32]);
      serve("rr", g, exp_r[33:2], exp_r[1], exp_r[0], 1'b0, 5, 1);
    end
    req_valid = '0;
    tick();

    for (int i = 0; i < 7; i++) begin
      stub_hang = vt[i].hang;
      req_x[32*vt[i].idx +: 32] = vt[i].x;
      req_y[32*vt[i].idx +: 32] = vt[i].y;
      req_rm[7*vt[i].idx +: 7]  = vt[i].rm;
      req_valid = N'(1) << vt[i].idx;
      serve($sformatf("vec%0d", i), vt[i].idx, vt[i].z, vt[i].inv, vt[i].ovf, vt[i].to, vt[i].lat, 0);
    end

    // A completion arriving after the timeout must be ignored.
    stub_hang = 1'b0;
    inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (rsp_valid != '0 || busy) seen = 1'b1;
    end
    chk("late_valid_ignored", seen, 0);

    // Reset while waiting on a stalled multiplier.
    stub_hang = 1'b1;
    req_x[31:0] = 32'h3F80_0000; req_y[31:0] = 32'h3F80_0000; req_rm[6:0] = 7'h00;
    req_valid = 4'b0001;
    wait_grant(ok);
    chk("rst_txn_grant", req_ready, ok ? 4'b0001 : 4'b1111);
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("rst_txn_waiting", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_last = N - 1;
    chk("rst_mid_ctl", {busy, rsp_valid, mif.mul_data_ready_o, rsp_to}, '0);
    chk("rst_mid_data", {rsp_z, mif.mul_x_exp_o, mif.mul_x_frac_o}, '0);
    stub_hang = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (rsp_valid != '0) seen = 1'b1;
    end
    chk("rst_no_response", seen, 0);
    req_x[127:96] = 32'h4000_0000; req_y[127:96] = 32'h3F80_0000; req_rm[27:21] = 7'h00;
    req_valid = 4'b1001;
    exp_r = stub_mul(req_x[31:0], req_y[31:0]);
    serve("rst_prio", 0, exp_r[33:2], exp_r[1], exp_r[0], 1'b0, 5, 0);

    for (int t = 0; t < 30; t++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        req_x[32*i +: 32] = rand_op();
        req_y[32*i +: 32] = rand_op();
        req_rm[7*i +: 7]  = ($urandom % 3 == 0) ? RM_RNE : 7'($urandom);
      end
      g = model_pick(mask, m_last);
      exp_r = stub_mul(req_x[32*g +: 32], req_y[32*g +: 32]);
      req_valid = mask;
      serve($sformatf("rnd%0d", t), g, exp_r[33:2], exp_r[1], exp_r[0], 1'b0,
            (req_rm[7*g +: 7] == RM_RNE) ? 6 : 5, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_mul_scheduler.md
# fpu_mul_scheduler

Shares the single-precision multiplier among `N_REQ` requesters using round-robin arbitration. Each accepted request is decomposed into sign, exponent, fraction and inf/NaN flags, and the multiplier is started with a one-cycle `data_ready` pulse. The block then waits for `data_valid` and returns the result to the granted requester. A watchdog forces a quiet-NaN timeout response if the multiplier never completes. The block sits between the FPU front end and the multiplier instance.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT_CYCLES`, 15: WAIT cycles without `mul_data_valid_i` before a forced timeout response (≥ 8).
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `req_valid_i` in N_REQ: request pending, one bit per requester; held until accepted.
- `req_ready_o` out N_REQ: one-hot accept pulse; the request is consumed in that cycle.
- `req_x_i`, `req_y_i` in 32*N_REQ: IEEE-754 operands, requester i at bits [32i+31:32i].
- `req_rounding_mode_i` in 7*N_REQ: rounding mode per requester.
- `rsp_valid_o` out N_REQ: one-hot, one-cycle response pulse to the granted requester; no backpressure.
- `rsp_z_o` out 32: result, valid when any `rsp_valid_o` bit is set.
- `rsp_invalid_o`, `rsp_overflow_o`, `rsp_timeout_o` out 1 each: exception flags, qualified by `rsp_valid_o`.
- `busy_o` out 1: high in every state except IDLE.
- `mul_data_ready_o` out 1: multiplier start pulse.
- `mul_rounding_mode_o` out 7: rounding mode sent to the multiplier.
- `mul_x_sign_o`, `mul_y_sign_o` out 1 each: operand signs.
- `mul_x_exp_o`, `mul_y_exp_o` out 8 each: operand exponents.
- `mul_x_frac_o`, `mul_y_frac_o` out 23 each: operand fractions.
- `mul_x_infinity_o`, `mul_y_infinity_o`, `mul_x_nan_o`, `mul_y_nan_o` out 1 each: operand class flags.
- `mul_data_valid_i` in 1: multiplier completion pulse.
- `mul_z_i` in 32: multiplier result.
- `mul_invalid_i`, `mul_overflow_i` in 1 each: multiplier exception flags.

## Operation
- **Reset.** Every output and register is 0, the state is IDLE, and the round-robin pointer `last` is N_REQ-1, so requester 0 has first priority.
- **Decomposition**, from registered operands:
  - infinity = (exp == 8'hFF) && (frac == 0).
  - nan = (exp == 8'hFF) && (frac != 0).
  - The `mul_*` operand outputs are driven from registers and held stable from ISSUE until the next accept.
- **IDLE.**
  - If `req_valid_i` is nonzero, grant the first set bit searching from `last+1` modulo N_REQ.
  - Pulse `req_ready_o[g]`, latch the operands and rounding mode, set `last = g`, and go to ISSUE.
  - If no request is pending, stay in IDLE.
- **ISSUE.** Drive `mul_data_ready_o` = 1 for exactly one cycle, clear the watchdog, and go to WAIT.
- **WAIT.**
  - On `mul_data_valid_i`: latch `mul_z_i`, `mul_invalid_i` and `mul_overflow_i`, clear timeout, and go to RESPOND.
  - Otherwise increment the watchdog. On its TIMEOUT_CYCLES-th consecutive cycle, load z = 32'h7FFF_FFFF, invalid = 0, overflow = 0, timeout = 1, and go to RESPOND.
- **RESPOND.** Pulse `rsp_valid_o[g]` together with the latched result and flags, then go to IDLE.
- **Ignored inputs.**
  - `mul_data_valid_i` outside WAIT is ignored; this covers a late completion after a timeout.
  - `req_valid_i` is not sampled outside IDLE.
- **Watchdog width.** $clog2(TIMEOUT_CYCLES+1) bits, saturating.
- **Rounding mode.** Passed through unchanged. Round-to-nearest-even is 7'h01.

## Timing
- Request accepted in cycle T (IDLE). `mul_data_ready_o` is high in T+1.
- Multiplier completion:
  - `mul_data_valid_i` in T+4 for non-RNE modes, T+5 for RNE.
  - `rsp_valid_o` in T+5 (non-RNE) or T+6 (RNE).
- The next accept is possible one cycle after RESPOND: T+6 or T+7.
- Timeout response: `rsp_valid_o` in T+2+TIMEOUT_CYCLES.
- **Reset mid-operation.**
  - `rst_i` in any state returns to IDLE next cycle with all outputs 0 and the pointer reset. The in-flight request is dropped with no response.
  - `rst_i` is shared with the multiplier, which also resets.
- **Simultaneous requests** are resolved by the pointer only. A requester that holds `req_valid_i` is granted within N_REQ grants.

## Structure
- Package `fpu_pkg`:
  - `QNAN` = 32'h7FFF_FFFF.
  - `RM_RNE` = 7'h01.
  - `EXP_MAX` = 8'hFF.
  - The scheduler state enum {IDLE, ISSUE, WAIT, RESPOND}.
  - Function `classify(exp, frac)` returning {inf, nan}.
- Sub-module `fpu_rr_arbiter`:
  - Parameter N_REQ.
  - Inputs: req vector, `last` pointer.
  - Outputs: one-hot grant and encoded index. Purely combinational.
- The pointer register lives in the scheduler.

## Test plan
- Requester 0, x = 0x40000000, y = 0x40400000, rm = 0, accepted at T → `mul_data_ready_o` at T+1; `rsp_valid_o` = 4'b0001 at T+5 with `rsp_z_o` = 0x40C00000 and all flags 0.
- Requesters 0 and 2 held valid from reset → grants 0, 2, 0, 2 (`req_ready_o` sequence 0001, 0100, 0001, 0100); each response goes to the matching requester only.
- Requester 1, x = 0x7FC00000 (NaN), y = 0x3F800000 → `mul_x_nan_o` = 1 at ISSUE; response z = 0x7FFFFFFF, `rsp_invalid_o` = 1.
- Requester 3, x = y = 0x7F000000 → z = 0x7F800000, `rsp_overflow_o` = 1; repeat with rm = 7'h01 → response one cycle later.
- Multiplier stub that never asserts valid, TIMEOUT_CYCLES = 15 → `rsp_valid_o` at T+17 with z = 0x7FFFFFFF and `rsp_timeout_o` = 1; a later `mul_data_valid_i` produces no response.
- `rst_i` asserted for one cycle during WAIT → next cycle IDLE, `busy_o` = 0, no `rsp_valid_o`; requester 0 has priority again.
